// File: rtl/mp3_key_ctrl.sv
// Button front end for the MP3 player: synchronize and debounce four keys,
// drive track next/pre with lockout, and step the volume with auto-repeat.
module mp3_key_ctrl #(
    parameter int DEB_CYCLES    = 200000,
    parameter int LOCKOUT       = 51,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 10000000,
    parameter int TRACKS        = 8,
    parameter int VOL_MAX       = 15,
    parameter int VOL_DEFAULT   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_btn_next,
    input  logic       i_btn_pre,
    input  logic       i_btn_vol_plus,
    input  logic       i_btn_vol_dec,
    output logic       o_next,
    output logic       o_pre,
    output logic       o_vol_plus,
    output logic       o_vol_dec,
    output logic       o_vol_up,
    output logic       o_vol_dn,
    output logic [3:0] o_track,
    output logic [3:0] o_volume
);

    localparam int DW   = $clog2(DEB_CYCLES + 1);
    localparam int LW   = $clog2(LOCKOUT + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    localparam int B_NEXT = 0;
    localparam int B_PRE  = 1;

    typedef enum logic {TK_IDLE, TK_LOCK} tk_state_e;
    typedef enum logic [1:0] {V_IDLE, V_FIRST, V_REPEAT} vol_state_e;

    logic [3:0]    btn_raw;
    logic [3:0]    sync1_q, sync2_q, deb_q, deb_prev_q;
    logic [DW-1:0] deb_cnt_q [4];
    logic [3:0]    rise;

    assign btn_raw = {i_btn_vol_dec, i_btn_vol_plus, i_btn_pre, i_btn_next};
    assign rise    = deb_q & ~deb_prev_q;

    // Counter only runs while the synchronized level disagrees with the debounced one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            for (int i = 0; i < 4; i++) deb_cnt_q[i] <= '0;
        end else begin
            sync1_q    <= btn_raw;
            sync2_q    <= sync1_q;
            deb_prev_q <= deb_q;
            for (int i = 0; i < 4; i++) begin
                if (sync2_q[i] == deb_q[i]) begin
                    deb_cnt_q[i] <= '0;
                end else if (deb_cnt_q[i] == DW'(DEB_CYCLES - 1)) begin
                    deb_q[i]     <= ~deb_q[i];
                    deb_cnt_q[i] <= '0;
                end else begin
                    deb_cnt_q[i] <= deb_cnt_q[i] + DW'(1);
                end
            end
        end
    end

    tk_state_e     tk_state_q, tk_state_d;
    logic [LW-1:0] lock_cnt_q, lock_cnt_d;
    logic [3:0]    track_q, track_d;
    logic          next_q, next_d, pre_q, pre_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tk_state_q <= TK_IDLE;
            lock_cnt_q <= '0;
            track_q    <= '0;
            next_q     <= 1'b0;
            pre_q      <= 1'b0;
        end else begin
            tk_state_q <= tk_state_d;
            lock_cnt_q <= lock_cnt_d;
            track_q    <= track_d;
            next_q     <= next_d;
            pre_q      <= pre_d;
        end
    end

    // Next has priority over pre; edges seen while locked are simply dropped.
    always_comb begin
        tk_state_d = tk_state_q;
        lock_cnt_d = lock_cnt_q;
        track_d    = track_q;
        next_d     = 1'b0;
        pre_d      = 1'b0;
        case (tk_state_q)
            TK_IDLE: begin
                if (rise[B_NEXT]) begin
                    next_d     = 1'b1;
                    track_d    = (track_q == 4'(TRACKS - 1)) ? 4'd0 : track_q + 4'd1;
                    tk_state_d = TK_LOCK;
                    lock_cnt_d = LW'(LOCKOUT - 1);
                end else if (rise[B_PRE]) begin
                    pre_d      = 1'b1;
                    track_d    = (track_q == 4'd0) ? 4'(TRACKS - 1) : track_q - 4'd1;
                    tk_state_d = TK_LOCK;
                    lock_cnt_d = LW'(LOCKOUT - 1);
                end
            end
            TK_LOCK: begin
                if (lock_cnt_q == '0) tk_state_d = TK_IDLE;
                else                  lock_cnt_d = lock_cnt_q - LW'(1);
            end
        endcase
    end

    vol_state_e    vol_state_q [2];
    vol_state_e    vol_state_d [2];
    logic [RW-1:0] rep_cnt_q [2];
    logic [RW-1:0] rep_cnt_d [2];
    logic [1:0]    lvl_v, rise_v, step;
    logic          both;
    logic [3:0]    vol_q, vol_d;
    logic          up_q, up_d, dn_q, dn_d;

    assign lvl_v  = deb_q[3:2];
    assign rise_v = rise[3:2];
    assign both   = &lvl_v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                vol_state_q[d] <= V_IDLE;
                rep_cnt_q[d]   <= '0;
            end
            vol_q <= 4'(VOL_DEFAULT);
            up_q  <= 1'b0;
            dn_q  <= 1'b0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                vol_state_q[d] <= vol_state_d[d];
                rep_cnt_q[d]   <= rep_cnt_d[d];
            end
            vol_q <= vol_d;
            up_q  <= up_d;
            dn_q  <= dn_d;
        end
    end

    // Index 0 steps up, index 1 steps down; holding both keys parks both machines.
    always_comb begin
        vol_state_d = vol_state_q;
        rep_cnt_d   = rep_cnt_q;
        step        = 2'b00;
        for (int d = 0; d < 2; d++) begin
            if (both || !lvl_v[d]) begin
                vol_state_d[d] = V_IDLE;
                rep_cnt_d[d]   = '0;
            end else begin
                case (vol_state_q[d])
                    V_IDLE: begin
                        if (rise_v[d]) begin
                            step[d]        = 1'b1;
                            vol_state_d[d] = V_FIRST;
                            rep_cnt_d[d]   = RW'(REPEAT_DELAY - 1);
                        end
                    end
                    V_FIRST, V_REPEAT: begin
                        if (rep_cnt_q[d] == '0) begin
                            step[d]        = 1'b1;
                            vol_state_d[d] = V_REPEAT;
                            rep_cnt_d[d]   = RW'(REPEAT_PERIOD - 1);
                        end else begin
                            rep_cnt_d[d] = rep_cnt_q[d] - RW'(1);
                        end
                    end
                    default: vol_state_d[d] = V_IDLE;
                endcase
            end
        end

        vol_d = vol_q;
        up_d  = 1'b0;
        dn_d  = 1'b0;
        if (step[0] && (vol_q != 4'(VOL_MAX))) begin
            vol_d = vol_q + 4'd1;
            up_d  = 1'b1;
        end else if (step[1] && (vol_q != 4'd0)) begin
            vol_d = vol_q - 4'd1;
            dn_d  = 1'b1;
        end
    end

    assign o_next     = next_q;
    assign o_pre      = pre_q;
    assign o_track    = track_q;
    assign o_vol_plus = deb_q[2];
    assign o_vol_dec  = deb_q[3];
    assign o_vol_up   = up_q;
    assign o_vol_dn   = dn_q;
    assign o_volume   = vol_q;

endmodule

// File: tb/tb_mp3_key_ctrl.sv
// Self-checking bench for mp3_key_ctrl: directed scenarios plus random key
// activity compared cycle by cycle against a behavioural model.
module tb_mp3_key_ctrl;

    localparam int DEB  = 4;
    localparam int LOCK = 10;
    localparam int RD   = 20;
    localparam int RP   = 8;
    localparam int TR   = 8;
    localparam int VMAX = 15;
    localparam int VDEF = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic b_next = 1'b0, b_pre = 1'b0, b_vp = 1'b0, b_vd = 1'b0;
    logic o_next, o_pre, o_vol_plus, o_vol_dec, o_vol_up, o_vol_dn;
    logic [3:0] o_track, o_volume;

    int checks = 0;
    int errors = 0;

    mp3_key_ctrl #(
        .DEB_CYCLES(DEB), .LOCKOUT(LOCK), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
        .TRACKS(TR), .VOL_MAX(VMAX), .VOL_DEFAULT(VDEF)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_btn_next(b_next), .i_btn_pre(b_pre),
        .i_btn_vol_plus(b_vp), .i_btn_vol_dec(b_vd),
        .o_next(o_next), .o_pre(o_pre), .o_vol_plus(o_vol_plus), .o_vol_dec(o_vol_dec),
        .o_vol_up(o_vol_up), .o_vol_dn(o_vol_dn), .o_track(o_track), .o_volume(o_volume)
    );

    always #5 clk = ~clk;

    // Model: raw history per key, debounced level = value held by the last DEB
    // synchronized samples, lockout as distance from the last accepted pulse,
    // volume repeat as arithmetic on hold time.
    int raw_hist [4][16];
    int m_deb [4];
    int m_deb_prev [4];
    int m_track, m_vol, m_next, m_pre, m_up, m_dn;
    int since_pulse;
    int m_active [2];
    int m_t [2];

    task automatic model_reset();
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 16; k++) raw_hist[b][k] = 0;
            m_deb[b] = 0;
            m_deb_prev[b] = 0;
        end
        m_track = 0; m_vol = VDEF;
        m_next = 0; m_pre = 0; m_up = 0; m_dn = 0;
        since_pulse = 1000;
        for (int d = 0; d < 2; d++) begin
            m_active[d] = 0;
            m_t[d] = 0;
        end
    endtask

    task automatic model_step();
        int raw [4];
        int rise [4];
        int lvl [4];
        int step [2];
        int same;
        if (!rst_n) begin
            model_reset();
            return;
        end
        raw[0] = int'(b_next); raw[1] = int'(b_pre); raw[2] = int'(b_vp); raw[3] = int'(b_vd);
        for (int b = 0; b < 4; b++) begin
            rise[b] = (m_deb[b] == 1 && m_deb_prev[b] == 0) ? 1 : 0;
            lvl[b]  = m_deb[b];
            for (int k = 15; k > 0; k--) raw_hist[b][k] = raw_hist[b][k-1];
            raw_hist[b][0] = raw[b];
            same = 1;
            for (int k = 3; k <= DEB + 1; k++)
                if (raw_hist[b][k] != raw_hist[b][2]) same = 0;
            m_deb_prev[b] = m_deb[b];
            if (same == 1) m_deb[b] = raw_hist[b][2];
        end

        m_next = 0; m_pre = 0;
        if (since_pulse < 1000) since_pulse++;
        if (since_pulse > LOCK && rise[0] == 1) begin
            m_next = 1; m_track = (m_track + 1) % TR; since_pulse = 0;
        end else if (since_pulse > LOCK && rise[1] == 1) begin
            m_pre = 1; m_track = (m_track + TR - 1) % TR; since_pulse = 0;
        end

        m_up = 0; m_dn = 0;
        for (int d = 0; d < 2; d++) begin
            step[d] = 0;
            if ((lvl[2] == 1 && lvl[3] == 1) || lvl[2+d] == 0) begin
                m_active[d] = 0;
            end else if (m_active[d] == 0) begin
                if (rise[2+d] == 1) begin
                    m_active[d] = 1; m_t[d] = 0; step[d] = 1;
                end
            end else begin
                m_t[d]++;
                if (m_t[d] >= RD && ((m_t[d] - RD) % RP) == 0) step[d] = 1;
            end
        end
        if (step[0] == 1 && m_vol < VMAX) begin
            m_vol++; m_up = 1;
        end else if (step[1] == 1 && m_vol > 0) begin
            m_vol--; m_dn = 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        b_next = 1'b0; b_pre = 1'b0; b_vp = 1'b0; b_vd = 1'b0;
        model_reset();
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (o_track !== 4'd0) begin errors++; $display("FAIL reset_track: got %0d want 0", o_track); end
        checks++; if (o_volume !== 4'(VDEF)) begin errors++; $display("FAIL reset_volume: got %0d want %0d", o_volume, VDEF); end
        checks++; if (o_next !== 1'b0 || o_pre !== 1'b0) begin errors++; $display("FAIL reset_track_pulses: got %b%b want 00", o_next, o_pre); end
        checks++; if (o_vol_up !== 1'b0 || o_vol_dn !== 1'b0) begin errors++; $display("FAIL reset_vol_pulses: got %b%b want 00", o_vol_up, o_vol_dn); end
        checks++; if (o_vol_plus !== 1'b0 || o_vol_dec !== 1'b0) begin errors++; $display("FAIL reset_levels: got %b%b want 00", o_vol_plus, o_vol_dec); end
    endtask

    task automatic test_bounce();
        int n_pulse = 0;
        int first_at = -1;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            b_next = 1'b1; tick(); if (o_next === 1'b1) n_pulse++; tick(); if (o_next === 1'b1) n_pulse++;
            b_next = 1'b0; tick(); if (o_next === 1'b1) n_pulse++; tick(); if (o_next === 1'b1) n_pulse++;
        end
        b_next = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            checks++;
            if (o_next !== 1'(m_next)) begin errors++; $display("FAIL bounce_next_model: got %b want %0d at %0d", o_next, m_next, k); end
            if (o_next === 1'b1) begin
                n_pulse++;
                if (first_at < 0) first_at = k;
            end
        end
        checks++; if (n_pulse != 1) begin errors++; $display("FAIL bounce_pulse_count: got %0d want 1", n_pulse); end
        checks++; if (first_at != DEB + 3) begin errors++; $display("FAIL bounce_latency: got %0d want %0d", first_at, DEB + 3); end
        checks++; if (o_track !== 4'd1) begin errors++; $display("FAIL bounce_track: got %0d want 1", o_track); end
        b_next = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_wrap_lockout();
        int n_pre = 0;
        int n_next = 0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            b_pre = 1'b1;
            repeat (8) begin tick(); if (o_pre === 1'b1) n_pre++; end
            b_pre = 1'b0;
            repeat (12) begin tick(); if (o_pre === 1'b1) n_pre++; end
            checks++;
            if (o_track !== 4'(7 - i) || o_track !== 4'(m_track)) begin
                errors++; $display("FAIL wrap_track: got %0d want %0d (press %0d)", o_track, 7 - i, i);
            end
        end
        checks++; if (n_pre != 8) begin errors++; $display("FAIL wrap_pre_count: got %0d want 8", n_pre); end
        b_next = 1'b1; repeat (5) begin tick(); if (o_next === 1'b1) n_next++; end
        b_next = 1'b0; repeat (5) begin tick(); if (o_next === 1'b1) n_next++; end
        b_next = 1'b1; repeat (5) begin tick(); if (o_next === 1'b1) n_next++; end
        b_next = 1'b0; repeat (20) begin tick(); if (o_next === 1'b1) n_next++; end
        checks++; if (n_next != 1) begin errors++; $display("FAIL lockout_next_count: got %0d want 1", n_next); end
        checks++; if (o_track !== 4'd1) begin errors++; $display("FAIL lockout_track: got %0d want 1", o_track); end
    endtask

    task automatic test_repeat();
        int up_at [16];
        int n_up = 0;
        int lvl_bad = 0;
        do_reset();
        b_vp = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            tick();
            if (o_vol_up === 1'b1) begin
                if (n_up < 16) up_at[n_up] = k;
                n_up++;
            end
            if (k >= DEB + 2 && o_vol_plus !== 1'b1) lvl_bad++;
            checks++;
            if (o_volume !== 4'(m_vol)) begin errors++; $display("FAIL repeat_volume_model: got %0d want %0d at %0d", o_volume, m_vol, k); end
        end
        checks++; if (n_up != VMAX - VDEF) begin errors++; $display("FAIL repeat_step_count: got %0d want %0d", n_up, VMAX - VDEF); end
        for (int i = 1; i < n_up && i < 16; i++) begin
            checks++;
            if (up_at[i] - up_at[0] != RD + (i - 1) * RP) begin
                errors++; $display("FAIL repeat_step_offset: step %0d got %0d want %0d", i, up_at[i] - up_at[0], RD + (i - 1) * RP);
            end
        end
        checks++; if (n_up > 0 && up_at[0] != DEB + 3) begin errors++; $display("FAIL repeat_first_step: got %0d want %0d", up_at[0], DEB + 3); end
        checks++; if (o_volume !== 4'(VMAX)) begin errors++; $display("FAIL repeat_saturate: got %0d want %0d", o_volume, VMAX); end
        checks++; if (lvl_bad != 0) begin errors++; $display("FAIL repeat_level_held: got %0d low cycles want 0", lvl_bad); end
        b_vp = 1'b0;
        repeat (10) tick();
        checks++; if (o_vol_plus !== 1'b0) begin errors++; $display("FAIL repeat_level_release: got %b want 0", o_vol_plus); end
    endtask

    task automatic test_conflict();
        int nn = 0, np = 0, nv = 0;
        do_reset();
        b_next = 1'b1; b_pre = 1'b1;
        repeat (8) begin tick(); if (o_next === 1'b1) nn++; if (o_pre === 1'b1) np++; end
        b_next = 1'b0; b_pre = 1'b0;
        repeat (15) begin tick(); if (o_next === 1'b1) nn++; if (o_pre === 1'b1) np++; end
        checks++; if (nn != 1 || np != 0) begin errors++; $display("FAIL conflict_pulses: got next=%0d pre=%0d want 1/0", nn, np); end
        checks++; if (o_track !== 4'd1) begin errors++; $display("FAIL conflict_track: got %0d want 1", o_track); end
        b_vp = 1'b1; b_vd = 1'b1;
        repeat (100) begin tick(); if (o_vol_up === 1'b1 || o_vol_dn === 1'b1) nv++; end
        checks++; if (nv != 0) begin errors++; $display("FAIL conflict_vol_pulses: got %0d want 0", nv); end
        checks++; if (o_volume !== 4'(VDEF)) begin errors++; $display("FAIL conflict_volume: got %0d want %0d", o_volume, VDEF); end
        checks++; if (o_vol_plus !== 1'b1 || o_vol_dec !== 1'b1) begin errors++; $display("FAIL conflict_levels: got %b%b want 11", o_vol_plus, o_vol_dec); end
        b_vp = 1'b0; b_vd = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_reset_mid();
        int ndn = 0;
        do_reset();
        b_vd = 1'b1;
        repeat (40) tick();
        checks++; if (o_volume !== 4'd5) begin errors++; $display("FAIL midrst_pre_volume: got %0d want 5", o_volume); end
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (o_volume !== 4'(VDEF)) begin errors++; $display("FAIL midrst_volume: got %0d want %0d", o_volume, VDEF); end
        checks++; if (o_vol_dec !== 1'b0 || o_vol_dn !== 1'b0) begin errors++; $display("FAIL midrst_dec: got %b%b want 00", o_vol_dec, o_vol_dn); end
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (15) begin tick(); if (o_vol_dn === 1'b1) ndn++; end
        checks++; if (ndn != 1) begin errors++; $display("FAIL midrst_step_count: got %0d want 1", ndn); end
        checks++; if (o_volume !== 4'(VDEF - 1)) begin errors++; $display("FAIL midrst_step_volume: got %0d want %0d", o_volume, VDEF - 1); end
        b_vd = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_random();
        int hold [4];
        logic lv [4];
        int local_err = 0;
        do_reset();
        for (int b = 0; b < 4; b++) begin hold[b] = 0; lv[b] = 1'b0; end
        for (int n = 0; n < 3000 && local_err < 20; n++) begin
            for (int b = 0; b < 4; b++) begin
                if (hold[b] == 0) begin
                    lv[b] = 1'($urandom_range(0, 1));
                    hold[b] = ($urandom_range(0, 9) < 3) ? int'($urandom_range(1, 3)) : int'($urandom_range(5, 60));
                end
                hold[b]--;
            end
            b_next = lv[0]; b_pre = lv[1]; b_vp = lv[2]; b_vd = lv[3];
            tick();
            checks++;
            if (o_next !== 1'(m_next) || o_pre !== 1'(m_pre)) begin
                errors++; local_err++; $display("FAIL rand_track_pulse: got %b%b want %0d%0d at %0d", o_next, o_pre, m_next, m_pre, n);
            end
            checks++;
            if (o_track !== 4'(m_track)) begin errors++; local_err++; $display("FAIL rand_track: got %0d want %0d at %0d", o_track, m_track, n); end
            checks++;
            if (o_volume !== 4'(m_vol)) begin errors++; local_err++; $display("FAIL rand_volume: got %0d want %0d at %0d", o_volume, m_vol, n); end
            checks++;
            if (o_vol_up !== 1'(m_up) || o_vol_dn !== 1'(m_dn)) begin
                errors++; local_err++; $display("FAIL rand_vol_pulse: got %b%b want %0d%0d at %0d", o_vol_up, o_vol_dn, m_up, m_dn, n);
            end
            checks++;
            if (o_vol_plus !== 1'(m_deb[2]) || o_vol_dec !== 1'(m_deb[3])) begin
                errors++; local_err++; $display("FAIL rand_levels: got %b%b want %0d%0d at %0d", o_vol_plus, o_vol_dec, m_deb[2], m_deb[3], n);
            end
        end
        b_next = 1'b0; b_pre = 1'b0; b_vp = 1'b0; b_vd = 1'b0;
        repeat (10) tick();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_bounce();
        test_wrap_lockout();
        test_repeat();
        test_conflict();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mp3_key_ctrl.md
MP3_KEY_CTRL -- requirements
Module: mp3_key_ctrl

Interface
REQ-001 The block SHALL have parameter DEB_CYCLES, default 200000, the number of consecutive stable cycles needed to accept a debounced edge (minimum 2).
REQ-002 The block SHALL have parameter LOCKOUT, default 51, the number of cycles after a next/pre pulse during which further next/pre edges are ignored.
REQ-003 The block SHALL have parameter REPEAT_DELAY, default 25000000, the number of hold cycles before volume auto-repeat starts.
REQ-004 The block SHALL have parameter REPEAT_PERIOD, default 10000000, the number of cycles between auto-repeat volume steps.
REQ-005 The block SHALL have parameter TRACKS, default 8, the track count (2..16).
REQ-006 The block SHALL have parameters VOL_MAX, default 15, and VOL_DEFAULT, default 8, the volume ceiling and the reset volume.
REQ-007 The block SHALL have port clk, input, 1 bit: the single system clock, all logic on its rising edge.
REQ-008 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-009 The block SHALL have inputs i_btn_next, i_btn_pre, i_btn_vol_plus and i_btn_vol_dec, 1 bit each: raw active-high button levels, asynchronous to clk and bouncing.
REQ-010 The block SHALL have outputs o_next and o_pre, 1 bit each: single-cycle pulses that feed the display's next/pre inputs.
REQ-011 The block SHALL have outputs o_vol_plus and o_vol_dec, 1 bit each: debounced held levels that feed the display's volume highlight inputs.
REQ-012 The block SHALL have outputs o_vol_up and o_vol_dn, 1 bit each: single-cycle pulses, one per actual volume change.
REQ-013 The block SHALL have output o_track, 4 bits: the current track index, 0..TRACKS-1.
REQ-014 The block SHALL have output o_volume, 4 bits: the current volume, 0..VOL_MAX.

Function
REQ-015 Each raw button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-016 Debounce SHALL use one counter per button: it counts while the synchronized level differs from the debounced level, clears on any agreement, and when it reaches DEB_CYCLES the debounced level toggles and the counter clears.
REQ-017 A rising edge of debounced next SHALL assert o_next for exactly 1 cycle, with latency DEB_CYCLES+3 clk edges from the first edge that samples a stable raw high.
REQ-018 On each o_next, o_track SHALL increment and wrap from TRACKS-1 to 0; on each o_pre, o_track SHALL decrement and wrap from 0 to TRACKS-1; o_track SHALL update in the same cycle the pulse is high.
REQ-019 Next/pre SHALL use a 2-state machine: IDLE accepts edges; LOCK is entered after any next/pre pulse, counts LOCKOUT cycles, then returns to IDLE.
REQ-020 Next/pre edges that arrive in LOCK SHALL be discarded, not queued.
REQ-021 If next and pre debounced rising edges occur in the same IDLE cycle, next SHALL win and pre SHALL be discarded.
REQ-022 o_vol_plus and o_vol_dec SHALL equal the debounced levels exactly, with no pulse shaping.
REQ-023 Volume SHALL use a 3-state machine per direction: IDLE -> FIRST on debounced press, with an immediate step.
REQ-024 In the volume state machine, FIRST -> REPEAT after REPEAT_DELAY held cycles, then one step every REPEAT_PERIOD cycles; any state -> IDLE on release.
REQ-025 A volume step SHALL saturate at VOL_MAX (up) and 0 (down); o_vol_up/o_vol_dn SHALL pulse only when o_volume actually changes, in the same cycle as the change.
REQ-026 While both debounced volume levels are high, no volume steps SHALL occur and both repeat timers SHALL hold at 0; stepping resumes with a fresh immediate step only on a new press edge.
REQ-027 Volume and track logic SHALL be independent; a simultaneous track change and volume step SHALL both take effect.

Reset
REQ-028 While rst_n is low, all outputs SHALL be 0 except o_volume = VOL_DEFAULT, and all synchronizers, debounced levels, counters and state machines SHALL be cleared to IDLE/0.
REQ-029 A reset asserted mid-hold or mid-lockout SHALL abort it; a button still held at release of reset SHALL be treated as a new press after debounce.

Verification
(Bench parameters: DEB_CYCLES=4, LOCKOUT=10, REPEAT_DELAY=20, REPEAT_PERIOD=8, TRACKS=8, VOL_MAX=15, VOL_DEFAULT=8.)
REQ-030 Reset values: hold rst_n low, then release -> o_track=0, o_volume=8, all pulses and levels 0.
REQ-031 Bounce rejection: toggle i_btn_next high/low every 2 cycles for 40 cycles, then hold it high -> exactly one o_next, 7 cycles after the stable high, and o_track=1.
REQ-032 Wrap and lockout: 8 clean presses of pre spaced 20 cycles -> o_track sequence 7,6,...,0. Then two next presses 5 cycles apart -> one o_next only.
REQ-033 Auto-repeat and saturation: hold vol_plus 200 cycles from volume 8 -> immediate step to 9, then steps every 8 cycles after 20, stopping at 15 with no o_vol_up pulse beyond 15; o_vol_plus high throughout.
REQ-034 Conflicts: press next and pre in the same cycle -> o_next only, o_track+1. Hold vol_plus and vol_dec together for 100 cycles -> o_volume unchanged.
REQ-035 Reset mid-operation: assert rst_n low during a vol_dec repeat -> o_volume returns to 8 immediately; vol_dec still held after release -> one step to 7 after debounce.
